// File: rtl/music_pkg.sv
// Shared definitions for the music/sound-effect path.
// Holds the arbiter FSM state encoding, tone and effect-length widths, the
// system clock rate, the note frequencies used by Musicmain, and a helper
// that turns a raw effect length into the number of ticks actually played.
package music_pkg;

  localparam int unsigned TONE_W = 32;
  localparam int unsigned LEN_W  = 8;
  localparam int unsigned CLK_HZ = 100_000_000;

  // Note frequencies in Hz; 0 is a rest.
  localparam logic [TONE_W-1:0] TONE_REST = 32'd0;
  localparam logic [TONE_W-1:0] TONE_C4   = 32'd262;
  localparam logic [TONE_W-1:0] TONE_D4   = 32'd294;
  localparam logic [TONE_W-1:0] TONE_E4   = 32'd330;
  localparam logic [TONE_W-1:0] TONE_F4   = 32'd349;
  localparam logic [TONE_W-1:0] TONE_G4   = 32'd392;
  localparam logic [TONE_W-1:0] TONE_A4   = 32'd440;
  localparam logic [TONE_W-1:0] TONE_B4   = 32'd494;
  localparam logic [TONE_W-1:0] TONE_C5   = 32'd523;
  localparam logic [TONE_W-1:0] TONE_E5   = 32'd659;
  localparam logic [TONE_W-1:0] TONE_G5   = 32'd784;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_GAP  = 2'd2
  } arb_state_e;

  // A zero length still plays for one tick.
  function automatic logic [LEN_W-1:0] eff_len(input logic [LEN_W-1:0] len);
    return (len == '0) ? LEN_W'(1) : len;
  endfunction

endpackage

// File: rtl/tick_divider.sv
// Duration tick generator.
// Counts 0..TICK_DIV-1 and flags the wrap cycle as a tick.
// Ports:
//   clk     - system clock
//   reset   - asynchronous active-low reset
//   clear_i - synchronously returns the count to 0 (restarts a tick period)
//   tick_o  - high during the last count of each period
module tick_divider #(
  parameter int unsigned TICK_DIV = 12_500_000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear_i,
  output logic tick_o
);

  localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt_q;

  assign tick_o = (cnt_q == LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (clear_i || tick_o) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/sfx_tone_arbiter.sv
// Shares the single tone generator between background music and NUM_REQ
// sound effects. In IDLE the music tone passes through; a request grants
// one effect (fixed priority, bit 0 highest, no preemption) which plays its
// latched tone for len ticks, then a silent gap of GAP_TICKS ticks, while
// music_pause freezes the beat counter upstream.
// Ports:
//   clk, reset         - clock, asynchronous active-low reset
//   music_tone         - tone from the music sequencer (0 = rest)
//   mute               - forces tone_out to 0, timing unchanged
//   req                - level requests, bit 0 highest priority
//   sfx_tone, sfx_len  - packed per-requester tone and length (ticks)
//   tone_out           - registered frequency to the tone generator
//   music_pause, busy  - high while an effect or its gap is active
//   ack, done          - one-cycle one-hot pulses on grant / end of gap
//   active_id          - index of the current/last granted requester
module sfx_tone_arbiter
  import music_pkg::*;
#(
  parameter  int unsigned NUM_REQ   = 4,
  parameter  int unsigned TICK_DIV  = 12_500_000,
  parameter  int unsigned GAP_TICKS = 1,
  localparam int unsigned ID_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [TONE_W-1:0]         music_tone,
  input  logic                      mute,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [TONE_W*NUM_REQ-1:0] sfx_tone,
  input  logic [LEN_W*NUM_REQ-1:0]  sfx_len,
  output logic [TONE_W-1:0]         tone_out,
  output logic                      music_pause,
  output logic [NUM_REQ-1:0]        ack,
  output logic [NUM_REQ-1:0]        done,
  output logic                      busy,
  output logic [ID_W-1:0]           active_id
);

  arb_state_e         state_q;
  logic [TONE_W-1:0]  tone_q;
  logic [TONE_W-1:0]  lat_tone_q;
  logic [LEN_W-1:0]   rem_q;
  logic               pause_q;
  logic [NUM_REQ-1:0] ack_q;
  logic [NUM_REQ-1:0] done_q;
  logic [ID_W-1:0]    id_q;

  logic               grant_any;
  logic [ID_W-1:0]    grant_idx;
  logic [TONE_W-1:0]  sel_tone;
  logic [LEN_W-1:0]   sel_len;
  logic               tick;
  logic               last_tick;
  logic               div_clear;

  // Lowest set index wins.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (req[i] && !grant_any) begin
        grant_any = 1'b1;
        grant_idx = ID_W'(i);
      end
    end
  end

  assign sel_tone = sfx_tone[grant_idx*TONE_W +: TONE_W];
  assign sel_len  = sfx_len[grant_idx*LEN_W +: LEN_W];

  assign last_tick = tick && (rem_q == LEN_W'(1));

  // Holding the divider cleared through IDLE covers the clear-on-grant;
  // the PLAY->GAP clear restarts the period for the gap.
  assign div_clear = (state_q == ST_IDLE) || ((state_q == ST_PLAY) && last_tick);

  tick_divider #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_divider (
    .clk     (clk),
    .reset   (reset),
    .clear_i (div_clear),
    .tick_o  (tick)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      tone_q     <= '0;
      lat_tone_q <= '0;
      rem_q      <= '0;
      pause_q    <= 1'b0;
      ack_q      <= '0;
      done_q     <= '0;
      id_q       <= '0;
    end else begin
      ack_q  <= '0;
      done_q <= '0;
      case (state_q)
        ST_IDLE: begin
          tone_q <= mute ? '0 : music_tone;
          if (grant_any) begin
            ack_q      <= NUM_REQ'(1) << grant_idx;
            id_q       <= grant_idx;
            lat_tone_q <= sel_tone;
            rem_q      <= eff_len(sel_len);
            pause_q    <= 1'b1;
            state_q    <= ST_PLAY;
          end
        end
        ST_PLAY: begin
          tone_q <= mute ? '0 : lat_tone_q;
          if (last_tick) begin
            rem_q   <= LEN_W'(GAP_TICKS);
            state_q <= ST_GAP;
          end else if (tick) begin
            rem_q <= rem_q - 1'b1;
          end
        end
        ST_GAP: begin
          tone_q <= '0;
          if (last_tick) begin
            done_q  <= NUM_REQ'(1) << id_q;
            pause_q <= 1'b0;
            rem_q   <= '0;
            state_q <= ST_IDLE;
          end else if (tick) begin
            rem_q <= rem_q - 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign tone_out    = tone_q;
  assign music_pause = pause_q;
  assign busy        = pause_q;
  assign ack         = ack_q;
  assign done        = done_q;
  assign active_id   = id_q;

endmodule

// File: tb/tb_sfx_tone_arbiter.sv
module tb_sfx_tone_arbiter;

  localparam int unsigned NREQ = 4;
  localparam int unsigned TDIV = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic [31:0]       music_tone;
  logic              mute;
  logic [NREQ-1:0]   req;
  logic [32*NREQ-1:0] sfx_tone;
  logic [8*NREQ-1:0] sfx_len;
  logic [31:0]       tone_out;
  logic              music_pause;
  logic [NREQ-1:0]   ack;
  logic [NREQ-1:0]   done;
  logic              busy;
  logic [1:0]        active_id;

  sfx_tone_arbiter #(
    .NUM_REQ   (NREQ),
    .TICK_DIV  (TDIV),
    .GAP_TICKS (1)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .music_tone  (music_tone),
    .mute        (mute),
    .req         (req),
    .sfx_tone    (sfx_tone),
    .sfx_len     (sfx_len),
    .tone_out    (tone_out),
    .music_pause (music_pause),
    .ack         (ack),
    .done        (done),
    .busy        (busy),
    .active_id   (active_id)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] tone;
    logic        pause;
    logic        busy;
    logic [3:0]  ack;
    logic [3:0]  done;
    logic [1:0]  id;
  } out_t;

  typedef struct {
    int          idx;
    logic [31:0] tone;
    logic [7:0]  len;
    logic        mute;
    logic [31:0] music;
    int          exp_play;   // expected PLAY cycles
  } vec_t;

  int n_cmp = 0;
  int n_err = 0;
  out_t sb_q[$];

  function automatic out_t sample();
    out_t s;
    s.tone  = tone_out;
    s.pause = music_pause;
    s.busy  = busy;
    s.ack   = ack;
    s.done  = done;
    s.id    = active_id;
    return s;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected per-cycle outputs from the cycle after the grant onwards.
  task automatic push_effect(input int idx, input logic [31:0] tone, input int play_cyc,
                             input logic mute_v, input logic [31:0] music, input bit with_idle);
    out_t e;
    for (int k = 0; k < play_cyc; k++) begin
      e = '{tone: (mute_v ? 32'd0 : tone), pause: 1'b1, busy: 1'b1, ack: 4'd0, done: 4'd0, id: 2'(idx)};
      sb_q.push_back(e);
    end
    for (int k = 0; k < int'(TDIV) - 1; k++) begin
      e = '{tone: 32'd0, pause: 1'b1, busy: 1'b1, ack: 4'd0, done: 4'd0, id: 2'(idx)};
      sb_q.push_back(e);
    end
    e = '{tone: 32'd0, pause: 1'b0, busy: 1'b0, ack: 4'd0, done: 4'(1 << idx), id: 2'(idx)};
    sb_q.push_back(e);
    if (with_idle) begin
      e = '{tone: (mute_v ? 32'd0 : music), pause: 1'b0, busy: 1'b0, ack: 4'd0, done: 4'd0, id: 2'(idx)};
      sb_q.push_back(e);
    end
  endtask

  task automatic drain(input string name);
    out_t e;
    while (sb_q.size() > 0) begin
      @(negedge clk);
      e = sb_q.pop_front();
      check(name, 64'(sample()), 64'(e));
    end
  endtask

  task automatic wait_ack(input string name, output bit got);
    got = 1'b0;
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge clk);
      if (ack != '0) got = 1'b1;
    end
    if (!got) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s: no ack within 20 cycles, got 0x%0h expected nonzero", name, ack);
    end
  endtask

  task automatic set_slot(input int idx, input logic [31:0] t, input logic [7:0] l);
    sfx_tone[idx*32 +: 32] = t;
    sfx_len[idx*8 +: 8]    = l;
  endtask

  vec_t vecs[6];

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    bit got;
    out_t z;
    z = '0;
    vecs[0] = '{idx: 1, tone: 32'd523, len: 8'd3,   mute: 1'b0, music: 32'd262, exp_play: 12};
    vecs[1] = '{idx: 3, tone: 32'd659, len: 8'd0,   mute: 1'b0, music: 32'd294, exp_play: 4};
    vecs[2] = '{idx: 2, tone: 32'd392, len: 8'd2,   mute: 1'b1, music: 32'd330, exp_play: 8};
    vecs[3] = '{idx: 2, tone: 32'd392, len: 8'd2,   mute: 1'b0, music: 32'd330, exp_play: 8};
    vecs[4] = '{idx: 0, tone: 32'd440, len: 8'd5,   mute: 1'b0, music: 32'd349, exp_play: 20};
    vecs[5] = '{idx: 1, tone: 32'd784, len: 8'd255, mute: 1'b0, music: 32'd262, exp_play: 1020};

    reset = 1'b0; music_tone = 32'd262; mute = 1'b0; req = '0; sfx_tone = '0; sfx_len = '0;
    #1;
    check("reset_async", 64'(sample()), 64'(z));
    repeat (3) @(negedge clk);
    check("reset_hold", 64'(sample()), 64'(z));
    reset = 1'b1;

    // Idle passthrough
    @(negedge clk);
    check("idle_pass", 64'(sample()), 64'({32'd262, 1'b0, 1'b0, 4'd0, 4'd0, 2'd0}));

    // Table-driven single effects
    foreach (vecs[r]) begin
      music_tone = vecs[r].music;
      mute       = vecs[r].mute;
      set_slot(vecs[r].idx, vecs[r].tone, vecs[r].len);
      @(negedge clk);
      check("row_idle_tone", 64'(tone_out), 64'(vecs[r].mute ? 32'd0 : vecs[r].music));
      check("row_idle_pause", 64'(music_pause), 64'd0);
      req[vecs[r].idx] = 1'b1;
      wait_ack("row_ack_wait", got);
      if (got) begin
        check("row_ack", 64'({ack, active_id, music_pause, done}),
              64'({4'(1 << vecs[r].idx), 2'(vecs[r].idx), 1'b1, 4'd0}));
        req[vecs[r].idx] = 1'b0;
        set_slot(vecs[r].idx, 32'hDEAD, 8'd7);   // must not affect latched values
        push_effect(vecs[r].idx, vecs[r].tone, vecs[r].exp_play, vecs[r].mute, vecs[r].music, 1'b1);
        drain("row_seq");
      end
    end
    mute = 1'b0;

    // Contention: req0 and req2 together, each held until its ack
    music_tone = 32'd262;
    set_slot(0, 32'd440, 8'd1);
    set_slot(2, 32'd330, 8'd2);
    @(negedge clk);
    req[0] = 1'b1; req[2] = 1'b1;
    wait_ack("cont_ack0_wait", got);
    if (got) begin
      check("cont_ack0", 64'({ack, active_id}), 64'({4'b0001, 2'd0}));
      req[0] = 1'b0;
      push_effect(0, 32'd440, 4, 1'b0, 32'd262, 1'b0);
      drain("cont_seq0");
      @(negedge clk);
      check("cont_ack2", 64'({ack, active_id, music_pause}), 64'({4'b0100, 2'd2, 1'b1}));
      req[2] = 1'b0;
      push_effect(2, 32'd330, 8, 1'b0, 32'd262, 1'b1);
      drain("cont_seq2");
    end

    // Reset two cycles into PLAY
    set_slot(1, 32'd523, 8'd3);
    @(negedge clk);
    req[1] = 1'b1;
    wait_ack("rst_ack_wait", got);
    req[1] = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_playing", 64'(tone_out), 64'd523);
    #2 reset = 1'b0;
    #1;
    check("rst_mid_play", 64'(sample()), 64'(z));
    @(negedge clk);
    check("rst_mid_hold", 64'(sample()), 64'(z));
    reset = 1'b1;
    music_tone = 32'd330;
    @(negedge clk);
    check("rst_release_pass", 64'(sample()), 64'({32'd330, 1'b0, 1'b0, 4'd0, 4'd0, 2'd0}));
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      check("rst_no_done", 64'({done, music_pause, tone_out}), 64'({4'd0, 1'b0, 32'd330}));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
